// File: rtl/vga_console.sv
// vga_console: byte-stream console front end for an 80x25 text memory.
// Define VGA_CONSOLE_TAB_EN to make 0x09 advance to the next 8-column stop.
module vga_console #(
    parameter int         COLS       = 80,
    parameter int         ROWS       = 25,
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  ch_data,
    input  logic        ch_valid,
    output logic        ch_ready,
    input  logic [7:0]  attr,
    input  logic        clr,
    output logic [15:0] mem_dw,
    output logic [10:0] mem_a,
    output logic        mem_we,
    input  logic [15:0] mem_dr,
    output logic [6:0]  cur_x,
    output logic [4:0]  cur_y,
    output logic        busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PUT    = 3'd1;
    localparam logic [2:0] S_SCR_RD = 3'd2;
    localparam logic [2:0] S_SCR_WR = 3'd3;
    localparam logic [2:0] S_FILL   = 3'd4;

    localparam logic [10:0] SCR_LAST  = 11'((ROWS - 1) * COLS - 1);
    localparam logic [10:0] CELL_LAST = 11'(ROWS * COLS - 1);
    localparam logic [10:0] COLS_A    = 11'(COLS);
    localparam logic [6:0]  X_LAST    = 7'(COLS - 1);
    localparam logic [4:0]  Y_LAST    = 5'(ROWS - 1);

    logic [2:0]  state_q, state_d;
    logic [6:0]  x_q, x_d;
    logic [4:0]  y_q, y_d;
    logic [10:0] s_q, s_d;
    logic [7:0]  attr_q, attr_d;
    logic        bs_q, bs_d;
    logic        clr_pend_q, clr_pend_d;
    logic        clearing_q, clearing_d;
    logic        mem_we_q, mem_we_d;
    logic [10:0] mem_a_q, mem_a_d;
    logic [15:0] mem_dw_q, mem_dw_d;
    logic        nl;

`ifdef VGA_CONSOLE_TAB_EN
    logic [7:0] tab_x;
    assign tab_x = {1'b0, x_q | 7'd7} + 8'd1;
`endif

    // y*80 + x built from shifts so no multiplier is needed
    function automatic logic [10:0] cell_addr(input logic [6:0] x,
                                              input logic [4:0] y);
        logic [10:0] yy;
        yy = {6'd0, y};
        return (yy << 6) + (yy << 4) + {4'd0, x};
    endfunction

    assign ch_ready = (state_q == S_IDLE) && !clr && !clr_pend_q;
    assign busy     = (state_q != S_IDLE);
    assign cur_x    = x_q;
    assign cur_y    = y_q;
    assign mem_we   = mem_we_q;
    assign mem_a    = mem_a_q;
    // Scroll copy forwards the read data straight into the write so a
    // cell moves in two cycles; the register keeps it once the write ends.
    assign mem_dw   = (state_q == S_SCR_WR) ? mem_dr : mem_dw_q;

    // Next-state, cursor and memory-port decode
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        s_d        = s_q;
        attr_d     = attr_q;
        bs_d       = bs_q;
        clearing_d = clearing_q;
        clr_pend_d = clr_pend_q | (clr & (state_q != S_IDLE));
        mem_we_d   = 1'b0;
        mem_a_d    = mem_a_q;
        mem_dw_d   = mem_dw_q;
        nl         = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (clr || clr_pend_q) begin
                    state_d    = S_FILL;
                    clearing_d = 1'b1;
                    attr_d     = attr;
                    s_d        = '0;
                    mem_a_d    = '0;
                    mem_we_d   = 1'b1;
                    mem_dw_d   = {attr, BLANK_CHAR};
                end else if (ch_valid) begin
                    attr_d = attr;
                    if (ch_data == 8'h0D) begin
                        x_d = '0;
                    end else if (ch_data == 8'h0A) begin
                        nl = 1'b1;
                    end else if (ch_data == 8'h08) begin
                        if (x_q != 7'd0) begin
                            x_d      = x_q - 7'd1;
                            bs_d     = 1'b1;
                            state_d  = S_PUT;
                            mem_we_d = 1'b1;
                            mem_a_d  = cell_addr(x_q - 7'd1, y_q);
                            mem_dw_d = {attr, BLANK_CHAR};
                        end
`ifdef VGA_CONSOLE_TAB_EN
                    end else if (ch_data == 8'h09) begin
                        if (tab_x >= 8'(COLS))
                            nl = 1'b1;
                        else
                            x_d = tab_x[6:0];
`endif
                    end else begin
                        bs_d     = 1'b0;
                        state_d  = S_PUT;
                        mem_we_d = 1'b1;
                        mem_a_d  = cell_addr(x_q, y_q);
                        mem_dw_d = {attr, ch_data};
                    end
                end
            end
            S_PUT: begin
                state_d = S_IDLE;
                if (!bs_q) begin
                    if (x_q == X_LAST)
                        nl = 1'b1;
                    else
                        x_d = x_q + 7'd1;
                end
            end
            S_SCR_RD: begin
                state_d  = S_SCR_WR;
                mem_a_d  = s_q;
                mem_we_d = 1'b1;
            end
            S_SCR_WR: begin
                mem_dw_d = mem_dr;
                s_d      = s_q + 11'd1;
                if (s_q == SCR_LAST) begin
                    state_d  = S_FILL;
                    mem_a_d  = s_q + 11'd1;
                    mem_we_d = 1'b1;
                    mem_dw_d = {attr_q, BLANK_CHAR};
                end else begin
                    state_d = S_SCR_RD;
                    mem_a_d = s_q + 11'd1 + COLS_A;
                end
            end
            S_FILL: begin
                if (s_q == CELL_LAST) begin
                    state_d    = S_IDLE;
                    clearing_d = 1'b0;
                    x_d        = '0;
                    if (clearing_q) begin
                        y_d        = '0;
                        clr_pend_d = 1'b0;
                    end else begin
                        y_d = Y_LAST;
                    end
                end else begin
                    s_d      = s_q + 11'd1;
                    mem_a_d  = s_q + 11'd1;
                    mem_we_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Line feed shared by LF, column wrap and tab wrap
        if (nl) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
                state_d    = S_SCR_RD;
                clearing_d = 1'b0;
                s_d        = '0;
                mem_a_d    = COLS_A;
                mem_we_d   = 1'b0;
            end else begin
                y_d = y_q + 5'd1;
            end
        end
    end

    // State and registered memory port
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            s_q        <= '0;
            attr_q     <= '0;
            bs_q       <= 1'b0;
            clr_pend_q <= 1'b0;
            clearing_q <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_a_q    <= '0;
            mem_dw_q   <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            s_q        <= s_d;
            attr_q     <= attr_d;
            bs_q       <= bs_d;
            clr_pend_q <= clr_pend_d;
            clearing_q <= clearing_d;
            mem_we_q   <= mem_we_d;
            mem_a_q    <= mem_a_d;
            mem_dw_q   <= mem_dw_d;
        end
    end

endmodule

// File: tb/tb_vga_console.sv
// tb_vga_console: directed scoreboard bench for vga_console.
// Expected memory writes are queued at stimulus time and popped per write.
module tb_vga_console;

    logic        clk;
    logic        sys_rst;
    logic [7:0]  ch_data;
    logic        ch_valid;
    logic        ch_ready;
    logic [7:0]  attr;
    logic        clr;
    logic [15:0] mem_dw;
    logic [10:0] mem_a;
    logic        mem_we;
    logic [15:0] mem_dr;
    logic [6:0]  cur_x;
    logic [4:0]  cur_y;
    logic        busy;

    vga_console dut (
        .sys_clk  (clk),
        .sys_rst  (sys_rst),
        .ch_data  (ch_data),
        .ch_valid (ch_valid),
        .ch_ready (ch_ready),
        .attr     (attr),
        .clr      (clr),
        .mem_dw   (mem_dw),
        .mem_a    (mem_a),
        .mem_we   (mem_we),
        .mem_dr   (mem_dr),
        .cur_x    (cur_x),
        .cur_y    (cur_y),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    logic        sb_off = 1'b0;
    logic [26:0] exp_q [$];
    logic [15:0] shadow [0:2047];
    logic [15:0] mem [0:2047];
    logic        pre_en = 1'b0;
    logic [10:0] pre_a = '0;
    logic [15:0] pre_d = '0;
    int row;
    int ncyc;

    // Text memory with registered read port
    always @(posedge clk) begin
        if (pre_en)
            mem[pre_a] <= pre_d;
        else if (mem_we === 1'b1)
            mem[mem_a] <= mem_dw;
        mem_dr <= mem[mem_a];
    end

    // Scoreboard: every write must match the oldest expectation
    always @(negedge clk) begin
        if (!sb_off && mem_we === 1'b1) begin
            n_vec++;
            assert (exp_q.size() != 0) else begin
                n_bad++;
                $error("FAIL unexpected_write: got a=%0d d=%h, required none",
                       mem_a, mem_dw);
            end
            if (exp_q.size() != 0) begin
                logic [26:0] e;
                e = exp_q.pop_front();
                n_vec++;
                assert ({mem_a, mem_dw} === e) else begin
                    n_bad++;
                    $error("FAIL write: got a=%0d d=%h, required a=%0d d=%h",
                           mem_a, mem_dw, e[26:16], e[15:0]);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h, required %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [10:0] a, input logic [15:0] d);
        exp_q.push_back({a, d});
        shadow[a] = d;
    endtask

    task automatic preload(input logic [10:0] a, input logic [15:0] d);
        @(negedge clk);
        pre_en = 1'b1;
        pre_a  = a;
        pre_d  = d;
        shadow[a] = d;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after acceptance
    task automatic send(input logic [7:0] b);
        int t;
        t = 0;
        while (ch_ready !== 1'b1 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) chk("ready_timeout", 32'(t), 32'd0);
        ch_data  = b;
        ch_valid = 1'b1;
        @(negedge clk);
        ch_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 10000) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        sys_rst  = 1'b1;
        ch_data  = '0;
        ch_valid = 1'b0;
        attr     = '0;
        clr      = 1'b0;
        repeat (3) @(negedge clk);
        sys_rst = 1'b0;
        @(negedge clk);
        chk("rst_we", mem_we, 0);
        chk("rst_a", mem_a, 0);
        chk("rst_dw", mem_dw, 0);
        chk("rst_x", cur_x, 0);
        chk("rst_y", cur_y, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", ch_ready, 1);

        attr = 8'h07;
        push(11'd0, 16'h0741);
        send(8'h41);
        chk("A_ready_low", ch_ready, 0);
        chk("A_busy", busy, 1);
        @(negedge clk);
        chk("A_x", cur_x, 1);
        chk("A_y", cur_y, 0);
        chk("A_ready_back", ch_ready, 1);
        chk("A_drained", exp_q.size(), 0);

        clr      = 1'b1;
        ch_valid = 1'b1;
        ch_data  = 8'h5A;
        for (int a = 0; a < 2000; a++) push(11'(a), 16'h0720);
        push(11'd0, 16'h075A);
        #1 chk("clr_blocks_ready", ch_ready, 0);
        @(negedge clk);
        clr = 1'b0;
        chk("clr_busy", busy, 1);
        wait_idle(ncyc);
        chk("clr_cycles", ncyc, 2000);
        chk("clr_x", cur_x, 0);
        chk("clr_y", cur_y, 0);
        chk("clr_fill_drained", exp_q.size(), 1);
        @(negedge clk);
        ch_valid = 1'b0;
        @(negedge clk);
        chk("clr_byte_x", cur_x, 1);
        chk("clr_byte_drained", exp_q.size(), 0);

        send(8'h0D);
        for (int i = 0; i < 80; i++) begin
            push(11'(i), {8'h07, 8'h21 + 8'(i)});
            send(8'h21 + 8'(i));
        end
        @(negedge clk);
        chk("wrap_x", cur_x, 0);
        chk("wrap_y", cur_y, 1);
        push(11'd80, 16'h0771);
        send(8'h71);
        @(negedge clk);
        chk("w81_x", cur_x, 1);
        chk("w81_drained", exp_q.size(), 0);

        send(8'h0D);
        send(8'h0A);
        send(8'h0A);
        for (int i = 0; i < 5; i++) begin
            push(11'(240 + i), {8'h07, 8'h61 + 8'(i)});
            send(8'h61 + 8'(i));
        end
        @(negedge clk);
        chk("pre_bs_x", cur_x, 5);
        push(11'd244, 16'h0720);
        send(8'h08);
        @(negedge clk);
        chk("bs_x", cur_x, 4);
        chk("bs_y", cur_y, 3);
        chk("bs_drained", exp_q.size(), 0);
        send(8'h0D);
        send(8'h08);
        @(negedge clk);
        chk("bs0_x", cur_x, 0);
        chk("bs0_y", cur_y, 3);
        chk("bs0_busy", busy, 0);
        row = 3;

`ifdef VGA_CONSOLE_TAB_EN
        for (int i = 0; i < 3; i++) begin
            push(11'(240 + i), 16'h0730);
            send(8'h30);
        end
        send(8'h09);
        @(negedge clk);
        chk("tab_x", cur_x, 8);
        chk("tab_drained", exp_q.size(), 0);
        send(8'h0D);
        for (int i = 0; i < 78; i++) begin
            push(11'(240 + i), 16'h0731);
            send(8'h31);
        end
        send(8'h09);
        @(negedge clk);
        chk("tabwrap_x", cur_x, 0);
        chk("tabwrap_y", cur_y, 4);
        row = 4;
`else
        push(11'd240, 16'h0709);
        send(8'h09);
        @(negedge clk);
        chk("tab_glyph_x", cur_x, 1);
`endif
        chk("tab_sec_drained", exp_q.size(), 0);

        preload(11'd80, 16'h1E42);
        @(negedge clk);
        send(8'h0D);
        for (int r = row; r < 24; r++) send(8'h0A);
        for (int i = 0; i < 5; i++) begin
            push(11'(1920 + i), {8'h07, 8'h56 + 8'(i)});
            send(8'h56 + 8'(i));
        end
        @(negedge clk);
        chk("pre_scr_x", cur_x, 5);
        chk("pre_scr_y", cur_y, 24);
        for (int s = 0; s < 1920; s++) push(11'(s), shadow[s + 80]);
        for (int a = 1920; a < 2000; a++) push(11'(a), 16'h0720);
        send(8'h0A);
        attr = 8'h55;
        wait_idle(ncyc);
        chk("scr_cycles", ncyc, 3920);
        chk("scr_x", cur_x, 0);
        chk("scr_y", cur_y, 24);
        chk("scr_cell0", mem[0], 16'h1E42);
        chk("scr_cell1999", mem[1999], 16'h0720);
        chk("scr_drained", exp_q.size(), 0);

        sb_off = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (100) @(negedge clk);
        chk("midclr_we", mem_we, 1);
        chk("midclr_y", cur_y, 24);
        sys_rst = 1'b1;
        #1;
        chk("abort_we", mem_we, 0);
        chk("abort_x", cur_x, 0);
        chk("abort_y", cur_y, 0);
        chk("abort_busy", busy, 0);
        @(negedge clk);
        sys_rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", ch_ready, 1);
        chk("abort_partial", mem[1500], shadow[1500]);
        sb_off = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
